// File: rtl/acc_pkg.sv
// Shared constants for the accumulator issue/writeback stage: opcodes,
// ALU select codes and the control FSM state encoding.
package acc_pkg;

    localparam int OP_W  = 3;
    localparam int SEL_W = 2;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_SLL  = 3'd2;
    localparam logic [OP_W-1:0] OP_CMP  = 3'd3;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd4;
    localparam logic [OP_W-1:0] OP_CLR  = 3'd5;

    localparam logic [SEL_W-1:0] ALU_ADD = 2'd0;
    localparam logic [SEL_W-1:0] ALU_SUB = 2'd1;
    localparam logic [SEL_W-1:0] ALU_SLL = 2'd2;
    localparam logic [SEL_W-1:0] ALU_CMP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Decoded control for one operation.
    typedef struct packed {
        logic [SEL_W-1:0] alu_s;
        logic             use_alu;
        logic             load;
        logic             clr;
        logic             illegal;
    } dec_t;

endpackage

// File: rtl/acc_op_decode.sv
// Combinational opcode decoder: maps an opcode onto the ALU select and the
// writeback source (ALU result, operand load, clear, or hold for illegal codes).
module acc_op_decode
    import acc_pkg::*;
(
    input  logic [OP_W-1:0]  op_i,
    output logic [SEL_W-1:0] alu_s_o,
    output logic             use_alu_o,
    output logic             load_o,
    output logic             clr_o,
    output logic             illegal_o
);

    dec_t dec;

    always_comb begin
        dec = '{alu_s: ALU_ADD, use_alu: 1'b0, load: 1'b0, clr: 1'b0, illegal: 1'b0};
        case (op_i)
            OP_ADD: begin
                dec.alu_s   = ALU_ADD;
                dec.use_alu = 1'b1;
            end
            OP_SUB: begin
                dec.alu_s   = ALU_SUB;
                dec.use_alu = 1'b1;
            end
            OP_SLL: begin
                dec.alu_s   = ALU_SLL;
                dec.use_alu = 1'b1;
            end
            OP_CMP: begin
                dec.alu_s   = ALU_CMP;
                dec.use_alu = 1'b1;
            end
            OP_LOAD: dec.load = 1'b1;
            OP_CLR:  dec.clr  = 1'b1;
            // Codes 6-7 keep ACC and still produce a result.
            default: dec.illegal = 1'b1;
        endcase
    end

    assign alu_s_o   = dec.alu_s;
    assign use_alu_o = dec.use_alu;
    assign load_o    = dec.load;
    assign clr_o     = dec.clr;
    assign illegal_o = dec.illegal;

endmodule

// File: rtl/acc_alu_ctrl.sv
// Accumulator issue-and-writeback stage: IDLE/EXEC/RESP control around an external ALU.
// Optional `ACC_FLAGS_EN adds registered zero/negative flags of ACC.
module acc_alu_ctrl
    import acc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_operand,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_s,
    input  logic [WIDTH-1:0] alu_o,
    output logic [WIDTH-1:0] acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             op_err
`ifdef ACC_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_n
`endif
);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             live_q;

    logic [SEL_W-1:0] dec_alu_s;
    logic             dec_use_alu;
    logic             dec_load;
    logic             dec_clr;
    logic             dec_illegal;
    logic             accept;

    // Decoding the registered opcode keeps alu_s stable through EXEC and RESP.
    acc_op_decode u_dec (
        .op_i      (op_q),
        .alu_s_o   (dec_alu_s),
        .use_alu_o (dec_use_alu),
        .load_o    (dec_load),
        .clr_o     (dec_clr),
        .illegal_o (dec_illegal)
    );

    // live_q holds in_ready low during reset and for the release cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    assign in_ready = live_q && (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = in_op;
                    operand_d = in_operand;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (dec_use_alu) begin
                    acc_d = alu_o;
                end else if (dec_load) begin
                    acc_d = operand_q;
                end else if (dec_clr) begin
                    acc_d = '0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_ADD;
            operand_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
        end
    end

    assign alu_a     = acc_q;
    assign alu_b     = operand_q;
    assign alu_s     = dec_alu_s;
    assign acc       = acc_q;
    assign res_valid = (state_q == RESP);
    assign res_data  = acc_q;
    assign op_err    = (state_q == EXEC) && dec_illegal;

`ifdef ACC_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_n_q, flag_n_d;

    // Derived from acc_d so the flags move on exactly the edge ACC does.
    assign flag_z_d = (acc_d == '0);
    assign flag_n_d = acc_d[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b1;
            flag_n_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
`endif

endmodule

// File: tb/tb_acc_alu_ctrl.sv
// Self-checking bench for acc_alu_ctrl: models the external ALU and the
// accumulator semantics, then runs directed, stall, reset and random scenarios.
module tb_acc_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_operand;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_s;
    logic [15:0] alu_o;
    logic [15:0] acc;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        op_err;
`ifdef ACC_FLAGS_EN
    logic        flag_z;
    logic        flag_n;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    acc_alu_ctrl #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_operand (in_operand),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_o      (alu_o),
        .acc        (acc),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .op_err     (op_err)
`ifdef ACC_FLAGS_EN
        ,
        .flag_z     (flag_z),
        .flag_n     (flag_n)
`endif
    );

    // External ALU: 0 ADD, 1 SUB, 2 SLL (shift >= 16 gives 0), 3 unsigned CMP.
    always_comb begin
        case (alu_s)
            2'd0:    alu_o = alu_a + alu_b;
            2'd1:    alu_o = alu_a - alu_b;
            2'd2:    alu_o = (alu_b >= 16'd16) ? 16'h0000 : (alu_a << alu_b[3:0]);
            default: alu_o = (alu_a > alu_b) ? 16'h0001 : ((alu_a == alu_b) ? 16'h0000 : 16'hFFFF);
        endcase
    end

    // Architectural effect of one operation on ACC.
    function automatic logic [15:0] model_acc(input logic [15:0] a, input logic [2:0] op,
                                              input logic [15:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: begin
                if (b >= 16'd16) return 16'h0000;
                return 16'((32'(a) * (32'd1 << b)) & 32'hFFFF);
            end
            3'd3: begin
                if (a > b) return 16'h0001;
                if (a == b) return 16'h0000;
                return 16'hFFFF;
            end
            3'd4: return b;
            3'd5: return 16'h0000;
            default: return a;
        endcase
    endfunction

    function automatic logic [1:0] model_sel(input logic [2:0] op);
        return (op < 3'd4) ? op[1:0] : 2'd0;
    endfunction

    // Drives one operation with res_ready held high and reports what was seen.
    task automatic send(input logic [2:0] op, input logic [15:0] b,
                        output logic [15:0] res, output int waitc, output int lat,
                        output int errs, output logic [1:0] ex_s, output logic [15:0] ex_a,
                        output logic [15:0] ex_b);
        res = '0; waitc = 0; lat = 0; errs = 0; ex_s = '0; ex_a = '0; ex_b = '0;
        res_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_operand = b;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waitc);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_op = 3'($urandom_range(0, 7)); in_operand = 16'($urandom);
        @(negedge clk);
        lat = 1; ex_s = alu_s; ex_a = alu_a; ex_b = alu_b;
        if (op_err) errs++;
        while (!res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
            if (op_err) errs++;
        end
        if (!res_valid) begin
            total++;
            $display("FAIL result_timeout: res_valid=%0b after %0d cycles, required 1", res_valid, lat);
            return;
        end
        res = res_data;
        @(posedge clk);
    endtask

    task automatic test_reset;
        logic [15:0] r; int w, l, e; logic [1:0] s; logic [15:0] a, b;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_operand = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (acc !== 16'h0 || res_valid !== 1'b0 || res_data !== 16'h0 || op_err !== 1'b0)
            $display("FAIL reset_state: acc=%h rv=%b rd=%h err=%b, required 0000 0 0000 0", acc, res_valid, res_data, op_err);
        else passed++;
        total++; if (alu_b !== 16'h0 || alu_s !== 2'd0 || alu_a !== 16'h0)
            $display("FAIL reset_alu: a=%h b=%h s=%0d, required 0000 0000 0", alu_a, alu_b, alu_s);
        else passed++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        else passed++;
        send(3'd4, 16'h1234, r, w, l, e, s, a, b);
        total++; if (r !== 16'h1234) $display("FAIL preload: res=%h, required 1234", r);
        else passed++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (acc !== 16'h0 || res_valid !== 1'b0) $display("FAIL reset_async: acc=%h rv=%b, required 0000 0", acc, res_valid);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1 || res_valid !== 1'b0 || acc !== 16'h0)
            $display("FAIL reset_release: rdy=%b rv=%b acc=%h, required 1 0 0000", in_ready, res_valid, acc);
        else passed++;
    endtask

    task automatic test_reset_midop;
        int seen;
        logic [15:0] r; int w, l, e; logic [1:0] s; logic [15:0] a, b;
        send(3'd4, 16'h00AA, r, w, l, e, s, a, b);
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_operand = 16'h0011; res_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        total++; if (seen !== 0 || acc !== 16'h0) $display("FAIL reset_midop: res_valid cycles=%0d acc=%h, required 0 0000", seen, acc);
        else passed++;
    endtask

    task automatic test_directed;
        logic [2:0]  ops [14] = '{3'd4, 3'd0, 3'd4, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3, 3'd4, 3'd1, 3'd4, 3'd2, 3'd4, 3'd2};
        logic [15:0] bs  [14] = '{16'd2, 16'd1, 16'd2, 16'd1, 16'd2, 16'd2, 16'd2, 16'd3, 16'd0, 16'd1, 16'd3, 16'd2, 16'd3, 16'd16};
        logic [15:0] exp [14] = '{16'h0002, 16'h0003, 16'h0002, 16'h0001, 16'h0002, 16'h0000, 16'h0002, 16'hFFFF,
                                  16'h0000, 16'hFFFF, 16'h0003, 16'h000C, 16'h0003, 16'h0000};
        logic [15:0] r; int w, l, e; logic [1:0] s; logic [15:0] a, b;
        for (int i = 0; i < 14; i++) begin
            send(ops[i], bs[i], r, w, l, e, s, a, b);
            total++; if (r !== exp[i]) $display("FAIL directed_%0d: res=%h, required %h", i, r, exp[i]);
            else passed++;
            if (i == 1) begin
                total++; if (l !== 2) $display("FAIL latency: res_valid at half-cycle %0d, required 2", l);
                else passed++;
                total++; if (s !== 2'd0 || a !== 16'h0002 || b !== 16'h0001)
                    $display("FAIL add_exec: s=%0d a=%h b=%h, required 0 0002 0001", s, a, b);
                else passed++;
            end
        end
    endtask

    task automatic test_stall;
        logic [15:0] r; int w, l, e; logic [1:0] s; logic [15:0] a, b;
        int bad, accepts;
        send(3'd4, 16'h0100, r, w, l, e, s, a, b);
        @(negedge clk);
        res_ready = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_operand = 16'h0020;
        @(posedge clk);
        #1 in_op = 3'd0; in_operand = 16'h0003;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 16'h0120 ||
                alu_s !== 2'd0 || alu_b !== 16'h0020) bad++;
            @(negedge clk);
        end
        total++; if (bad !== 0) $display("FAIL stall_hold: %0d unstable cycles, required 0", bad);
        else passed++;
        res_ready = 1'b1;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                accepts++;
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
        end
        total++; if (accepts !== 1 || acc !== 16'h0123)
            $display("FAIL stall_release: accepts=%0d acc=%h, required 1 0123", accepts, acc);
        else passed++;
    endtask

    task automatic test_illegal;
        logic [15:0] r; int w, l, e; logic [1:0] s; logic [15:0] a, b;
        send(3'd4, 16'h0005, r, w, l, e, s, a, b);
        send(3'd7, 16'hBEEF, r, w, l, e, s, a, b);
        total++; if (e !== 1 || r !== 16'h0005 || s !== 2'd0)
            $display("FAIL illegal: err_pulses=%0d res=%h sel=%0d, required 1 0005 0", e, r, s);
        else passed++;
        send(3'd0, 16'h0001, r, w, l, e, s, a, b);
        total++; if (e !== 0 || r !== 16'h0006) $display("FAIL after_illegal: err_pulses=%0d res=%h, required 0 0006", e, r);
        else passed++;
    endtask

`ifdef ACC_FLAGS_EN
    task automatic test_flags;
        logic [15:0] r; int w, l, e; logic [1:0] s; logic [15:0] a, b;
        send(3'd4, 16'h0007, r, w, l, e, s, a, b);
        send(3'd5, 16'h0000, r, w, l, e, s, a, b);
        @(negedge clk);
        total++; if (flag_z !== 1'b1 || flag_n !== 1'b0) $display("FAIL flags_clr: z=%b n=%b, required 1 0", flag_z, flag_n);
        else passed++;
        send(3'd4, 16'h8000, r, w, l, e, s, a, b);
        @(negedge clk);
        total++; if (flag_z !== 1'b0 || flag_n !== 1'b1) $display("FAIL flags_neg: z=%b n=%b, required 0 1", flag_z, flag_n);
        else passed++;
    endtask
`endif

    task automatic test_random;
        logic [15:0] model, b, r, ea, eb; int w, l, e; logic [1:0] s;
        logic [2:0] op;
        int bad_res, bad_exec, bad_err, bad_tp;
        send(3'd5, 16'h0000, r, w, l, e, s, ea, eb);
        model = 16'h0000;
        bad_res = 0; bad_exec = 0; bad_err = 0; bad_tp = 0;
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd2) b = 16'($urandom_range(0, 20));
            else if (op == 3'd3 && $urandom_range(0, 3) == 0) b = model;
            else b = 16'($urandom);
            send(op, b, r, w, l, e, s, ea, eb);
            if (s !== model_sel(op) || ea !== model || eb !== b) bad_exec++;
            if (e !== ((op >= 3'd6) ? 1 : 0)) bad_err++;
            if (w !== 0 || l !== 2) bad_tp++;
            model = model_acc(model, op, b);
            if (r !== model) begin
                bad_res++;
                if (bad_res <= 3) $display("FAIL random_res_%0d: op=%0d b=%h res=%h, required %h", i, op, b, r, model);
            end
        end
        total++; if (bad_res !== 0) $display("FAIL random_results: %0d wrong, required 0", bad_res);
        else passed++;
        total++; if (bad_exec !== 0) $display("FAIL random_exec_ports: %0d wrong, required 0", bad_exec);
        else passed++;
        total++; if (bad_err !== 0) $display("FAIL random_op_err: %0d wrong, required 0", bad_err);
        else passed++;
        total++; if (bad_tp !== 0) $display("FAIL random_timing: %0d wrong, required 0", bad_tp);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_illegal();
        test_reset_midop();
`ifdef ACC_FLAGS_EN
        test_flags();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
